if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline; owns the PC.
- Fetches each 32-bit instruction as four byte beats over the shared byte-wide memory port, assembling them little-endian.
- Presents if_pc/if_inst to the IF/ID pipeline register.
- Requests a pipeline stall from ctrl while a fetch is incomplete, and accepts branch/jump redirects from EX.

---
 rtl/if_stage_pkg.sv | 28 ++
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared types and constants for the instruction-fetch stage: reset/stall
// encodings, bus widths and the IF state encoding.
// -----------------------------------------------------------------------------
package if_stage_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  typedef logic [5:0]  stall_bus_t;
  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [7:0]  byte_t;

  localparam inst_t ZERO_WORD = 32'h0000_0000;

  // Beat index of the final byte of a 32-bit instruction.
  localparam logic [1:0] LAST_BEAT = 2'd3;

  typedef enum logic [1:0] {
    IF_FETCH = 2'b00,
    IF_DRAIN = 2'b01,
    IF_DONE  = 2'b10
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Byte-wide memory port shared between the fetch stage and the memory
// controller. One beat is outstanding at a time; mem_req/mem_addr stay stable
// until mem_valid returns the byte.
//   mem_req   : fetch beat request          (master -> slave)
//   mem_addr  : byte address of the beat    (master -> slave)
//   mem_valid : byte returned this cycle    (slave -> master)
//   mem_rdata : returned byte               (slave -> master)
// -----------------------------------------------------------------------------
interface if_stage_if;
  import if_stage_pkg::*;

  logic       mem_req;
  inst_addr_t mem_addr;
  logic       mem_valid;
  byte_t      mem_rdata;

  modport master (output mem_req, mem_addr, input mem_valid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_valid, mem_rdata);

endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, fetches
// each instruction as four little-endian byte beats over the shared memory
// port, and presents the assembled word to the IF/ID register.
//   clk, rst    : clock, synchronous active-high reset
//   stall       : ctrl stall vector, stall[0] holds the PC stage
//   br_flag     : redirect pulse from EX, br_target valid with it
//   mem         : byte-wide memory port (master side)
//   stallreq_if : asks ctrl to stall while a fetch is incomplete
//   if_pc       : PC of the instruction on if_inst
//   if_inst     : last completely assembled instruction
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  stall_bus_t   stall,
  input  logic         br_flag,
  input  inst_addr_t   br_target,
  if_stage_if.master   mem,
  output logic         stallreq_if,
  output inst_addr_t   if_pc,
  output inst_t        if_inst
);

  if_state_e   state;
  inst_addr_t  pc;
  inst_addr_t  drain_pc;
  logic [1:0]  beat;
  // Bytes 0..2 of the instruction in flight; beat 3 comes straight from
  // mem_rdata when the word is assembled.
  logic [23:0] byte_buf;

  // Only the PC-stage hold bit matters here.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // In DRAIN pc/beat are deliberately left untouched so mem_addr keeps
  // pointing at the outstanding beat; the redirect target waits in drain_pc.
  assign mem.mem_addr = pc + {30'd0, beat};
  assign mem.mem_req  = (rst != RST_ENABLE) && (state != IF_DONE);
  assign stallreq_if  = (state != IF_DONE);

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= IF_FETCH;
      pc       <= RESET_PC;
      drain_pc <= ZERO_WORD;
      beat     <= 2'd0;
      byte_buf <= 24'd0;
      if_pc    <= ZERO_WORD;
      if_inst  <= ZERO_WORD;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of pc/beat/state.
      case (state)
        IF_FETCH: begin
          if (br_flag) begin
            if (mem.mem_valid) begin
              // Beat completes this edge: drop the byte, restart at target.
              pc   <= br_target;
              beat <= 2'd0;
            end else begin
              // Beat still outstanding: must wait for it before moving on.
              drain_pc <= br_target;
              state    <= IF_DRAIN;
            end
          end else if (mem.mem_valid) begin
            if (beat == LAST_BEAT) begin
              if_inst <= {mem.mem_rdata, byte_buf};
              if_pc   <= pc;
              state   <= IF_DONE;
            end else begin
              // Shifting in from the top leaves byte k at bits [8k+7:8k]
              // once beats 0..2 have arrived.
              byte_buf <= {mem.mem_rdata, byte_buf[23:8]};
              beat     <= beat + 2'd1;
            end
          end
        end

        IF_DONE: begin
          if (br_flag) begin
            pc    <= br_target;
            beat  <= 2'd0;
            state <= IF_FETCH;
          end else if (stall[0] == NO_STOP) begin
            pc    <= pc + 32'd4;
            beat  <= 2'd0;
            state <= IF_FETCH;
          end
        end

        IF_DRAIN: begin
          if (mem.mem_valid) begin
            // A redirect arriving on the drain-exit edge is the newer one.
            pc    <= br_flag ? br_target : drain_pc;
            beat  <= 2'd0;
            state <= IF_FETCH;
          end else if (br_flag) begin
            drain_pc <= br_target;
          end
        end

        default: state <= IF_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. The bench plays the memory controller, keeps a
// transaction-level model of the fetch stage (which word lives at which PC,
// how many beats of the current fetch have been accepted, whether the stage
// is busy, draining or idle) and compares the DUT against it every cycle,
// alongside hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  logic       clk;
  logic       rst;
  stall_bus_t stall;
  logic       br_flag;
  inst_addr_t br_target;
  logic       stallreq_if;
  inst_addr_t if_pc;
  inst_t      if_inst;

  if_stage_if mem_bus();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_flag     (br_flag),
    .br_target   (br_target),
    .mem         (mem_bus),
    .stallreq_if (stallreq_if),
    .if_pc       (if_pc),
    .if_inst     (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: the first word is addi a0,x0,1; everything else is a
  // simple address-derived pattern.
  function automatic byte_t mem_byte(input inst_addr_t a);
    byte_t lo [4];
    lo[0] = 8'h13; lo[1] = 8'h05; lo[2] = 8'h10; lo[3] = 8'h00;
    if (a < 32'd4) return lo[a[1:0]];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic inst_t word_at(input inst_addr_t a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: busy = collecting beats, drain = waiting out a beat that
  // was abandoned by a redirect, idle = word presented, waiting for release.
  // ---------------------------------------------------------------------------
  typedef enum int {M_BUSY, M_DRAIN, M_IDLE} m_phase_e;

  bit         m_known = 0;
  m_phase_e   m_phase;
  inst_addr_t m_base;
  int         m_got;
  inst_addr_t m_pend;
  inst_addr_t m_drain_addr;
  inst_addr_t m_out_pc;
  inst_t      m_out_inst;

  task automatic model_step();
    if (rst) begin
      m_known    = 1;
      m_phase    = M_BUSY;
      m_base     = 32'h0;
      m_got      = 0;
      m_out_pc   = 32'h0;
      m_out_inst = 32'h0;
      return;
    end
    if (!m_known) return;
    case (m_phase)
      M_BUSY: begin
        if (br_flag && mem_bus.mem_valid) begin
          m_base = br_target;
          m_got  = 0;
        end else if (br_flag) begin
          m_drain_addr = m_base + m_got;
          m_pend       = br_target;
          m_phase      = M_DRAIN;
        end else if (mem_bus.mem_valid) begin
          m_got++;
          if (m_got == 4) begin
            m_out_pc   = m_base;
            m_out_inst = word_at(m_base);
            m_phase    = M_IDLE;
          end
        end
      end
      M_DRAIN: begin
        if (mem_bus.mem_valid) begin
          m_base  = br_flag ? br_target : m_pend;
          m_got   = 0;
          m_phase = M_BUSY;
        end else if (br_flag) begin
          m_pend = br_target;
        end
      end
      default: begin
        if (br_flag || !stall[0]) begin
          m_base  = br_flag ? br_target : m_base + 32'd4;
          m_got   = 0;
          m_phase = M_BUSY;
        end
      end
    endcase
  endtask

  // Compare on the falling edge, then advance the model with the inputs the
  // DUT will sample on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        logic       exp_req;
        inst_addr_t exp_addr;
        exp_req  = !rst && (m_phase != M_IDLE);
        exp_addr = (m_phase == M_DRAIN) ? m_drain_addr : m_base + m_got;
        check("model_mem_req", {31'd0, mem_bus.mem_req}, {31'd0, exp_req});
        if (!rst)
          check("model_stallreq", {31'd0, stallreq_if}, {31'd0, m_phase != M_IDLE});
        if (exp_req) check("model_mem_addr", mem_bus.mem_addr, exp_addr);
        check("model_if_pc", if_pc, m_out_pc);
        check("model_if_inst", if_inst, m_out_inst);
      end
      model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory controller: wait `gap` idle cycles, then return one byte.
  task automatic respond(input int gap);
    mem_bus.mem_valid = 1'b0;
    repeat (gap) tick();
    mem_bus.mem_valid = 1'b1;
    mem_bus.mem_rdata = mem_byte(mem_bus.mem_addr);
    tick();
    mem_bus.mem_valid = 1'b0;
  endtask

  initial begin
    int gaps [4] = '{2, 0, 3, 1};

    rst               = 1'b1;
    stall             = 6'b0;
    br_flag           = 1'b0;
    br_target         = 32'h0;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_rdata = 8'h00;
    tick();
    tick();
    check("reset_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check("reset_if_pc", if_pc, 32'h0);
    check("reset_if_inst", if_inst, 32'h0);
    rst = 1'b0;
    #1;

    // 1: back-to-back beats at 0..3
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", mem_bus.mem_addr, i);
      respond(0);
    end
    check("t1_if_inst", if_inst, 32'h0010_0513);
    check("t1_if_pc", if_pc, 32'h0);
    check("t1_stallreq_done", {31'd0, stallreq_if}, 32'd0);
    check("t1_mem_req_done", {31'd0, mem_bus.mem_req}, 32'd0);
    tick();
    check("t1_stallreq_next", {31'd0, stallreq_if}, 32'd1);
    check("t1_next_addr", mem_bus.mem_addr, 32'h4);

    // 2: gapped beats; stall[0] raised during the fetch must not matter
    stall = 6'b000011;
    for (int i = 0; i < 4; i++) respond(gaps[i]);
    check("t2_if_inst", if_inst, 32'h5D5C_5F5E);
    check("t2_if_pc", if_pc, 32'h4);

    // 3: DONE held by stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      check("t3_mem_req_hold", {31'd0, mem_bus.mem_req}, 32'd0);
      check("t3_if_pc_hold", if_pc, 32'h4);
      tick();
    end
    stall = 6'b0;
    tick();
    check("t3_next_addr", mem_bus.mem_addr, 32'h8);

    // 4: redirect while beat 2 is outstanding, re-redirect inside DRAIN
    respond(0);
    respond(0);
    tick();
    br_flag   = 1'b1;
    br_target = 32'h300;
    tick();
    br_flag = 1'b0;
    check("t4_drain_addr", mem_bus.mem_addr, 32'hA);
    tick();
    br_flag   = 1'b1;
    br_target = 32'h100;
    tick();
    br_flag = 1'b0;
    check("t4_drain_addr_hold", mem_bus.mem_addr, 32'hA);
    check("t4_drain_req", {31'd0, mem_bus.mem_req}, 32'd1);
    mem_bus.mem_valid = 1'b1;
    mem_bus.mem_rdata = 8'hEE;
    tick();
    mem_bus.mem_valid = 1'b0;
    check("t4_target_addr", mem_bus.mem_addr, 32'h100);
    check("t4_if_pc_kept", if_pc, 32'h4);
    for (int i = 0; i < 4; i++) respond(0);
    check("t4_if_pc", if_pc, 32'h100);
    check("t4_if_inst", if_inst, 32'h5859_5A5B);
    tick();

    // 5: redirect coincident with the last beat
    respond(0);
    respond(0);
    respond(0);
    br_flag           = 1'b1;
    br_target         = 32'h40;
    mem_bus.mem_valid = 1'b1;
    mem_bus.mem_rdata = mem_byte(32'h107);
    tick();
    br_flag           = 1'b0;
    mem_bus.mem_valid = 1'b0;
    check("t5_addr", mem_bus.mem_addr, 32'h40);
    check("t5_if_pc_kept", if_pc, 32'h100);
    check("t5_if_inst_kept", if_inst, 32'h5859_5A5B);

    // 6: wrap at the top of the address space, then reset mid-fetch
    br_flag           = 1'b1;
    br_target         = 32'hFFFF_FFFC;
    mem_bus.mem_valid = 1'b1;
    mem_bus.mem_rdata = 8'h00;
    tick();
    br_flag           = 1'b0;
    mem_bus.mem_valid = 1'b0;
    check("t6_top_addr", mem_bus.mem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) respond(0);
    check("t6_if_pc", if_pc, 32'hFFFF_FFFC);
    check("t6_if_inst", if_inst, 32'h5A5B_5859);
    tick();
    check("t6_wrap_addr", mem_bus.mem_addr, 32'h0);
    respond(0);
    respond(0);
    rst = 1'b1;
    #1;
    check("t6_rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    tick();
    check("t6_rst_if_pc", if_pc, 32'h0);
    check("t6_rst_if_inst", if_inst, 32'h0);
    check("t6_rst_mem_req_after", {31'd0, mem_bus.mem_req}, 32'd0);
    rst = 1'b0;
    #1;
    check("t6_restart_req", {31'd0, mem_bus.mem_req}, 32'd1);
    check("t6_restart_addr", mem_bus.mem_addr, 32'h0);
    stall = 6'b000001;
    for (int i = 0; i < 4; i++) respond(1);
    check("t6_refetch_inst", if_inst, 32'h0010_0513);

    // Redirect out of a stalled DONE
    tick();
    br_flag   = 1'b1;
    br_target = 32'h10;
    tick();
    br_flag = 1'b0;
    stall   = 6'b0;
    check("done_redirect_addr", mem_bus.mem_addr, 32'h10);
    check("done_redirect_if_pc", if_pc, 32'h0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
